led_sequencer: RTL and testbench

Parametrised LED pattern sequencer for board status and bring-up displays. It drives an N-bit LED bank through a selectable pattern: rotate up, rotate down, bounce or fill bar. Steps are timed by an internal clock prescaler, a run/pause control and a power-of-two rate select. It sits directly on the board LED pins, clocked from the 50 MHz board clock.

---
 rtl/led_seq_pkg.sv | 43 ++++
 rtl/tick_prescaler.sv | 49 ++++
 rtl/led_sequencer.sv | 156 +++++++++++++++
 tb/tb_led_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_seq_pkg
// Purpose : Shared types and helpers for the LED sequencer: pattern mode
//           encoding, bounce direction and the one-hot / thermometer
//           pattern builders.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_UP = 2'b00,
        MODE_ROT_DN = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    // Widest LED bank the helpers can build; the top checks N_LEDS against it.
    localparam int c_MAX_LEDS = 64;

    // Single lit LED at index p.
    function automatic logic [c_MAX_LEDS-1:0] f_onehot(input int unsigned p);
        logic [c_MAX_LEDS-1:0] v;
        v = {{(c_MAX_LEDS-1){1'b0}}, 1'b1} << p;
        return v;
    endfunction

    // Bar of LEDs p..0 lit. For p = c_MAX_LEDS-1 the shift yields 0 and the
    // subtraction wraps to all ones, which is the correct full bar.
    function automatic logic [c_MAX_LEDS-1:0] f_thermo(input int unsigned p);
        logic [c_MAX_LEDS-1:0] v;
        v = ({{(c_MAX_LEDS-1){1'b0}}, 1'b1} << (p + 1)) - 1'b1;
        return v;
    endfunction

endpackage : led_seq_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : tick_prescaler
// Purpose : Free-running clock divider producing a one-cycle tick every
//           TICK_DIV enabled clock cycles.
// Ports   : clk    - clock
//           rst_n  - asynchronous active-low reset
//           enable - 1 = count, 0 = hold count and suppress tick
//           clr    - synchronous clear of the count
//           tick   - high while enabled and the count is at TICK_DIV-1
// Rev     : 1.0  initial release
// ============================================================================
module tick_prescaler #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clr,
    output logic tick
);

    localparam int c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TICK_DIV - 1);

    generate
        if (TICK_DIV < 1) begin : g_bad_div
            $error("tick_prescaler: TICK_DIV must be >= 1");
        end
    endgenerate

    logic [c_CNT_W-1:0] r_cnt;

    // With TICK_DIV = 1 the count is permanently 0 == c_LAST, so tick
    // follows enable directly.
    assign tick = enable && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : led_sequencer
// Purpose : N-bit LED pattern sequencer (rotate up, rotate down, bounce,
//           fill bar) stepped by a prescaled tick and a power-of-two rate.
// Ports   : clk      - board clock
//           rst_n    - asynchronous active-low reset
//           enable   - 1 = run, 0 = pause (everything holds)
//           mode     - 00 rot up, 01 rot down, 10 bounce, 11 fill
//           rate     - step period = TICK_DIV * 2^rate cycles
//           sync_clr - synchronous restart to the reset state
//           led      - registered LED drive, bit 0 = first LED
//           pos      - registered position index
//           step     - one-cycle pulse in the cycle led/pos take new values
// Rev     : 1.0  initial release
// ============================================================================
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS   = 4,
    parameter int TICK_DIV = 12500000,
    parameter int RATE_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [RATE_W-1:0]         rate,
    input  logic                      sync_clr,
    output logic [N_LEDS-1:0]         led,
    output logic [$clog2(N_LEDS)-1:0] pos,
    output logic                      step
);

    localparam int c_POS_W = $clog2(N_LEDS);
    localparam logic [c_POS_W-1:0] c_POS_MAX = c_POS_W'(N_LEDS - 1);
    // The rate counter must reach 2^rate - 1 for the largest rate value.
    localparam int c_RCNT_W = (1 << RATE_W) - 1;

    generate
        if (N_LEDS < 2) begin : g_bad_leds
            $error("led_sequencer: N_LEDS must be >= 2");
        end
        if (N_LEDS > c_MAX_LEDS) begin : g_too_many_leds
            $error("led_sequencer: N_LEDS exceeds pattern helper width");
        end
    endgenerate

    logic [N_LEDS-1:0]   r_led;
    logic [c_POS_W-1:0]  r_pos;
    dir_t                r_dir;
    logic                r_step;
    logic [c_RCNT_W-1:0] r_rate_cnt;

    logic                w_tick;
    logic                w_step;
    logic [c_RCNT_W:0]   w_thresh;
    mode_t               w_mode;
    logic [c_POS_W-1:0]  w_pos_inc;
    logic [c_POS_W-1:0]  w_pos_dec;
    logic [c_POS_W-1:0]  w_pos_nxt;
    logic [N_LEDS-1:0]   w_led_nxt;
    dir_t                w_dir_nxt;
    logic [c_RCNT_W-1:0] w_rate_nxt;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .clr    (sync_clr),
        .tick   (w_tick)
    );

    assign w_mode   = mode_t'(mode);
    assign w_thresh = ((c_RCNT_W + 1)'(1) << rate) - 1'b1;

    // ">=" rather than "==" so that lowering rate mid-count steps on the
    // next tick instead of waiting for the counter to wrap.
    assign w_step = w_tick && ({1'b0, r_rate_cnt} >= w_thresh);

    assign w_pos_inc = (r_pos == c_POS_MAX) ? '0 : r_pos + 1'b1;
    assign w_pos_dec = (r_pos == '0) ? c_POS_MAX : r_pos - 1'b1;

    // Next-state / next-output logic; everything holds unless a step fires.
    always_comb begin
        w_pos_nxt  = r_pos;
        w_led_nxt  = r_led;
        w_dir_nxt  = r_dir;
        w_rate_nxt = r_rate_cnt;

        if (w_tick) begin
            w_rate_nxt = w_step ? '0 : r_rate_cnt + 1'b1;
        end

        if (w_step) begin
            unique case (w_mode)
                MODE_ROT_UP: begin
                    w_pos_nxt = w_pos_inc;
                    w_led_nxt = N_LEDS'(f_onehot(32'(w_pos_inc)));
                end
                MODE_ROT_DN: begin
                    w_pos_nxt = w_pos_dec;
                    w_led_nxt = N_LEDS'(f_onehot(32'(w_pos_dec)));
                end
                MODE_BOUNCE: begin
                    // End points override whatever direction was stored, so
                    // each end LED is shown exactly once per sweep.
                    if (r_pos == c_POS_MAX) begin
                        w_dir_nxt = DIR_DN;
                    end else if (r_pos == '0) begin
                        w_dir_nxt = DIR_UP;
                    end
                    w_pos_nxt = (w_dir_nxt == DIR_UP) ? w_pos_inc : w_pos_dec;
                    w_led_nxt = N_LEDS'(f_onehot(32'(w_pos_nxt)));
                end
                MODE_FILL: begin
                    w_pos_nxt = w_pos_inc;
                    w_led_nxt = N_LEDS'(f_thermo(32'(w_pos_inc)));
                end
                default: begin
                    w_pos_nxt = r_pos;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led      <= N_LEDS'(1);
            r_pos      <= '0;
            r_dir      <= DIR_UP;
            r_step     <= 1'b0;
            r_rate_cnt <= '0;
        end else if (sync_clr) begin
            r_led      <= N_LEDS'(1);
            r_pos      <= '0;
            r_dir      <= DIR_UP;
            r_step     <= 1'b0;
            r_rate_cnt <= '0;
        end else begin
            r_led      <= w_led_nxt;
            r_pos      <= w_pos_nxt;
            r_dir      <= w_dir_nxt;
            r_step     <= w_step;
            r_rate_cnt <= w_rate_nxt;
        end
    end

    assign led  = r_led;
    assign pos  = r_pos;
    assign step = r_step;

endmodule : led_sequencer
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_sequencer
// Purpose : Self-checking bench for led_sequencer (N_LEDS=4, TICK_DIV=4).
//           A behavioural model predicts every step and pushes the expected
//           led/pos into a scoreboard queue; a monitor pops on each step
//           pulse and checks hold behaviour between steps.
// Rev     : 1.0  initial release
// ============================================================================
module tb_led_sequencer;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int RW = 2;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [1:0]    mode;
    logic [RW-1:0] rate;
    logic          sync_clr;
    logic [N-1:0]  led;
    logic [PW-1:0] pos;
    logic          step;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_sequencer #(
        .N_LEDS   (N),
        .TICK_DIV (TD),
        .RATE_W   (RW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .mode     (mode),
        .rate     (rate),
        .sync_clr (sync_clr),
        .led      (led),
        .pos      (pos),
        .step     (step)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference model: enabled-cycle counting and pattern arithmetic.
    // ------------------------------------------------------------------
    typedef struct {
        int led;
        int pos;
    } exp_t;

    exp_t sb_q[$];

    int m_pre;    // enabled cycles into the current base tick
    int m_ticks;  // ticks since the last step
    int m_pos;
    int m_dir;    // +1 up, -1 down
    int m_led;

    function automatic void m_reset();
        m_pre   = 0;
        m_ticks = 0;
        m_pos   = 0;
        m_dir   = 1;
        m_led   = 1;
    endfunction

    function automatic void m_do_step();
        exp_t e;
        case (mode)
            2'd0: begin m_pos = (m_pos + 1) % N;     m_led = 1 << m_pos; end
            2'd1: begin m_pos = (m_pos + N - 1) % N; m_led = 1 << m_pos; end
            2'd2: begin
                if (m_pos == N - 1) m_dir = -1;
                if (m_pos == 0)     m_dir = 1;
                m_pos = m_pos + m_dir;
                m_led = 1 << m_pos;
            end
            default: begin m_pos = (m_pos + 1) % N; m_led = (2 << m_pos) - 1; end
        endcase
        e.led = m_led;
        e.pos = m_pos;
        sb_q.push_back(e);
    endfunction

    function automatic void m_clock();
        bit tick;
        if (sync_clr) begin
            m_reset();
        end else if (enable) begin
            tick  = (m_pre == TD - 1);
            m_pre = tick ? 0 : m_pre + 1;
            if (tick) begin
                // A step is due once at least 2^rate ticks have elapsed.
                if (m_ticks + 1 >= (1 << rate)) begin
                    m_ticks = 0;
                    m_do_step();
                end else begin
                    m_ticks++;
                end
            end
        end
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
                sb_q.delete();
            end else begin
                m_clock();
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (step === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_step", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("step_led", int'(led), e.led);
                    chk("step_pos", int'(pos), e.pos);
                end
            end else begin
                if (sb_q.size() != 0) begin
                    chk("missing_step", 0, 1);
                    e = sb_q.pop_front();
                end
                chk("hold_led", int'(led), m_led);
                chk("hold_pos", int'(pos), m_pos);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with directed checks
    // ------------------------------------------------------------------
    int t1_led[4] = '{2, 4, 8, 1};
    int t2_led[4] = '{8, 4, 2, 1};
    int t3_led[7] = '{2, 4, 8, 4, 2, 1, 2};
    int t3_pos[7] = '{1, 2, 3, 2, 1, 0, 1};
    int t4_led[4] = '{3, 7, 15, 1};

    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step !== 1'b1 && n < 200);
        if (step !== 1'b1) begin
            chk("step_timeout", 0, 1);
        end
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        enable   = 1'b0;
        sync_clr = 1'b0;
        mode     = 2'd0;
        rate     = '0;
        repeat (3) @(negedge clk);
        chk("reset_led", int'(led), 1);
        chk("reset_pos", int'(pos), 0);
        chk("reset_step", int'(step), 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Rotate up, one step per base tick.
        for (int i = 0; i < 4; i++) begin
            wait_step(n);
            chk("t1_period", n, 4);
            chk("t1_led", int'(led), t1_led[i]);
            chk("t1_pos", int'(pos), (i + 1) % 4);
        end

        // Rotate down from pos 0.
        mode = 2'd1;
        for (int i = 0; i < 4; i++) begin
            wait_step(n);
            chk("t2_led", int'(led), t2_led[i]);
            chk("t2_pos", int'(pos), (3 - i + 4) % 4);
        end

        // Bounce from pos 0.
        mode = 2'd2;
        for (int i = 0; i < 7; i++) begin
            wait_step(n);
            chk("t3_led", int'(led), t3_led[i]);
            chk("t3_pos", int'(pos), t3_pos[i]);
        end

        // Restart at pos 0, then fill, then back to rotate up.
        sync_clr = 1'b1;
        mode     = 2'd3;
        @(negedge clk);
        sync_clr = 1'b0;
        chk("clr_pos", int'(pos), 0);
        for (int i = 0; i < 4; i++) begin
            wait_step(n);
            chk("t4_led", int'(led), t4_led[i]);
            chk("t4_pos", int'(pos), (i + 1) % 4);
        end
        mode = 2'd0;
        wait_step(n);
        chk("t4_fill_to_rot_led", int'(led), 2);

        // Rate 2: 16-cycle period, then a 10-cycle pause mid-period.
        rate = 2'd2;
        wait_step(n);
        chk("t5_period16", n, 16);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        wait_step(n);
        chk("t5_paused_period", n + 15, 26);
        chk("t5_led", int'(led), 8);

        // Drop rate to 0 with two ticks already counted.
        repeat (8) @(negedge clk);
        rate = 2'd0;
        wait_step(n);
        chk("t5_rate_drop", n + 8, 12);
        chk("t5_rate_drop_led", int'(led), 1);

        // Asynchronous reset while step is high, between clock edges.
        wait_step(n);
        chk("t6_pre_led", int'(led), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_led", int'(led), 1);
        chk("t6_async_pos", int'(pos), 0);
        chk("t6_async_step", int'(step), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // sync_clr on the edge where a step is due.
        wait_step(n);
        chk("t6_step_before_clr", n, 4);
        repeat (3) @(negedge clk);
        sync_clr = 1'b1;
        @(negedge clk);
        sync_clr = 1'b0;
        chk("t6_clr_step", int'(step), 0);
        chk("t6_clr_led", int'(led), 1);
        chk("t6_clr_pos", int'(pos), 0);

        // Randomised run checked by the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            sync_clr = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) rate = RW'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) enable = ($urandom_range(0, 3) != 0);
        end
        sync_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_led_sequencer
`default_nettype wire
